// File: rtl/mat_det_pkg.sv
// Shared constants, FSM state type and 3x3-to-4x4 index mapping for the
// determinant loader.
package mat_det_pkg;

  localparam int unsigned MAT_DIM    = 4;
  localparam int unsigned MAT_ELEMS  = 16;
  localparam int unsigned MAT3_ELEMS = 9;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WAIT = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Row-major 3x3 element index -> row-major 4x4 position (top-left block).
  function automatic logic [IDX_W-1:0] idx3_to_4(input logic [IDX_W-1:0] i3);
    int unsigned row;
    int unsigned col;
    row = 32'(i3) / 32'd3;
    col = 32'(i3) % 32'd3;
    return IDX_W'(row * MAT_DIM + col);
  endfunction

endpackage

// File: rtl/mat_det_loader.sv
// Streams matrix elements into a 16-element operand bus, waits the determinant
// latency, then returns the result. Optional 3x3 mode: MAT_DET_LOADER_SIZE3_EN.
module mat_det_loader
  import mat_det_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RES_W   = 8,
  parameter int unsigned DET_LAT = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [MAT_ELEMS*DATA_W-1:0] mat_flat,
  input  logic [RES_W-1:0]            det_result,
  output logic [RES_W-1:0]            res_data,
  output logic                        res_valid,
  input  logic                        res_ready,
`ifdef MAT_DET_LOADER_SIZE3_EN
  input  logic                        mode_3x3,
`endif
  output logic                        busy
);

  state_e                             state_q, state_d;
  logic [IDX_W-1:0]                   idx_q, idx_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [MAT_ELEMS-1:0][DATA_W-1:0]   mat_q, mat_d;
  logic [RES_W-1:0]                   res_q, res_d;
  logic                               in_ready_q, in_ready_d;
  logic                               res_valid_q, res_valid_d;
  logic                               busy_q, busy_d;

  logic                               accept_c;
  logic [IDX_W-1:0]                   wr_pos_c;
  logic                               last_c;
  logic                               fill3_c;

  assign accept_c = in_valid & in_ready_q;

`ifdef MAT_DET_LOADER_SIZE3_EN
  logic mode_q, mode_d;
  logic mode_now_c;

  // Mode is latched on element 0 and governs placement of the whole matrix.
  always_comb begin
    mode_now_c = (idx_q == '0) ? mode_3x3 : mode_q;
    mode_d     = mode_q;
    if (accept_c && (idx_q == '0)) begin
      mode_d = mode_3x3;
    end
    if (mode_now_c) begin
      wr_pos_c = idx3_to_4(idx_q);
      last_c   = (idx_q == IDX_W'(MAT3_ELEMS - 1));
      fill3_c  = 1'b1;
    end else begin
      wr_pos_c = idx_q;
      last_c   = (idx_q == IDX_W'(MAT_ELEMS - 1));
      fill3_c  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
    end
  end
`else
  assign wr_pos_c = idx_q;
  assign last_c   = (idx_q == IDX_W'(MAT_ELEMS - 1));
  assign fill3_c  = 1'b0;
`endif

  // Next-state, datapath updates and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    mat_d   = mat_q;
    res_d   = res_q;

    case (state_q)
      LOAD: begin
        if (accept_c) begin
          mat_d[wr_pos_c] = in_data;
          idx_d           = idx_q + IDX_W'(1);
          if (last_c) begin
            if (fill3_c) begin
              // Embed 3x3 so the 4x4 determinant equals the 3x3 one.
              mat_d[3]  = '0;
              mat_d[7]  = '0;
              mat_d[11] = '0;
              mat_d[12] = '0;
              mat_d[13] = '0;
              mat_d[14] = '0;
              mat_d[15] = DATA_W'(1);
            end
            idx_d   = '0;
            cnt_d   = CNT_W'(DET_LAT - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_d   = det_result;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      OUT: begin
        if (res_valid_q && res_ready) begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    in_ready_d  = (state_d == LOAD);
    res_valid_d = (state_d == OUT);
    busy_d      = (state_d != LOAD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      mat_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      mat_q       <= mat_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res_data  = res_q;
  assign mat_flat  = mat_q;

endmodule
